mem: RTL and testbench



---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_frame_counter.sv | 43 ++++
 rtl/mem.sv | 80 ++++++++
 tb/tb_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, width helpers and the default pixel type for the mem
// frame buffer.
package mem_pkg;

  // Default frame geometry: 30x30 pixels of 3 bytes each
  localparam int DEF_HEIGHT = 30;
  localparam int DEF_WIDTH  = 30;
  localparam int DEF_BPP    = 3;

  // Pixel word at the default depth; modules re-derive it from their own BPP
  typedef logic [8*DEF_BPP-1:0] pixel_t;

  // Bits needed to index n entries (at least one bit)
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the values 0..n inclusive
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_frame_counter.sv
// Counts accepted pixel writes, saturating at one full frame, and raises a
// sticky done flag on the edge where the count reaches a full frame.
// Both registers clear asynchronously while rst (active-low) is held.
module mem_frame_counter
  import mem_pkg::*;
#(
  parameter int PIXELS = DEF_HEIGHT * DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr_accept,
  output logic o_done
);

  localparam int CW = cnt_width(PIXELS);
  localparam logic [CW-1:0] FULL      = CW'(PIXELS);
  localparam logic [CW-1:0] LAST      = CW'(PIXELS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] r_wcnt;
  logic          r_done;

  // Write counter: one step per accepted write, held once a frame is counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt <= '0;
    end else if (i_wr_accept && (r_wcnt != FULL)) begin
      r_wcnt <= r_wcnt + CNT_ONE;
    end
  end

  // Sticky done: set by the write that brings the count to a full frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else if (i_wr_accept && (r_wcnt == LAST)) begin
      r_done <= 1'b1;
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/mem.sv
// Frame buffer: HEIGHT x WIDTH pixels of BPP bytes, one write port and one
// read port. A producer fills the frame by address; done goes high once a
// full frame worth of in-range writes has been seen and stays high until rst.
// Optional build macro MEM_READ_REG_EN: when defined, read_data is
// registered (one cycle latency, cleared by rst); otherwise the read is
// combinational. Storage is never cleared by rst.
module mem
  import mem_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BPP    = DEF_BPP
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   read_en,
  input  logic                                   write_en,
  input  logic [addr_width(HEIGHT*WIDTH)-1:0]    rd_addr,
  input  logic [addr_width(HEIGHT*WIDTH)-1:0]    wr_addr,
  input  logic [8*BPP-1:0]                       write_data,
  output logic [8*BPP-1:0]                       read_data,
  output logic                                   done
);

  localparam int PIXELS = HEIGHT * WIDTH;
  localparam int AW     = addr_width(PIXELS);
  localparam int DW     = 8 * BPP;

  // One extra bit so the limit is representable even when PIXELS == 2**AW
  localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(PIXELS);

  typedef logic [DW-1:0] pix_t;

  pix_t r_mem [PIXELS];

  logic w_wr_ok;
  logic w_rd_ok;
  pix_t w_rd_data;

  // An unknown address makes the compare unknown, which the if() below
  // treats as false, so such writes neither land nor count.
  assign w_wr_ok = write_en && ({1'b0, wr_addr} < ADDR_LIMIT);
  assign w_rd_ok = read_en  && ({1'b0, rd_addr} < ADDR_LIMIT);

  // Pixel storage: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= write_data;
    end
  end

  assign w_rd_data = w_rd_ok ? r_mem[rd_addr] : '0;

`ifdef MEM_READ_REG_EN
  pix_t r_rd_data;

  // Registered read port: samples storage before this edge's write lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_data;
    end
  end

  assign read_data = r_rd_data;
`else
  assign read_data = w_rd_data;
`endif

  mem_frame_counter #(
    .PIXELS (PIXELS)
  ) u_frame_counter (
    .clk         (clk),
    .rst         (rst),
    .i_wr_accept (w_wr_ok),
    .o_done      (done)
  );

endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for mem: expected read values are queued when a read is
// driven and compared when the DUT presents the data. Works for both the
// combinational build and the MEM_READ_REG_EN build.
module tb_mem;

  localparam int PIXELS = 900;
  localparam int AW     = 10;
  localparam int DW     = 24;

  logic          clk;
  logic          rst;
  logic          read_en;
  logic          write_en;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          done;

  int n_vec;
  int n_err;
  logic [DW-1:0] exp_q [$];

  mem #(
    .HEIGHT (30),
    .WIDTH  (30),
    .BPP    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_en    (read_en),
    .write_en   (write_en),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is bounded in cycles
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [DW-1:0] frame_px(input int a);
    return DW'(a * 32'h010101);
  endfunction

  function automatic logic [DW-1:0] alt_px(input int a);
    return DW'(a * 32'h000301) ^ 24'h5A5A5A;
  endfunction

  // One write per call; inputs change on the falling edge
  task automatic write_px(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    write_en   = 1'b1;
    wr_addr    = AW'(a);
    write_data = d;
  endtask

  task automatic write_idle();
    @(negedge clk);
    write_en = 1'b0;
  endtask

  // Drive a read, queue its expected value, then compare when it appears
  task automatic read_px(input string tag, input int a, input logic en, input logic [DW-1:0] e);
    logic [DW-1:0] want;
    @(negedge clk);
    rd_addr = AW'(a);
    read_en = en;
    exp_q.push_back(e);
`ifdef MEM_READ_REG_EN
    @(posedge clk);
    #1;
`else
    #2;
`endif
    want = exp_q.pop_front();
    check($sformatf("%s[%0d]", tag, a), 32'(read_data), 32'(want));
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    read_en    = 1'b0;
    write_en   = 1'b0;
    rd_addr    = '0;
    wr_addr    = '0;
    write_data = '0;

    // Reset held with no writes
    repeat (3) @(posedge clk);
    #1;
    check("done_in_reset", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_after_release", 32'(done), 32'd0);

    // Full frame: data = addr * 0x010101; done only after the last write
    for (int i = 0; i < PIXELS - 1; i++) write_px(i, frame_px(i));
    @(negedge clk);
    check("done_before_last", 32'(done), 32'd0);
    write_en   = 1'b1;
    wr_addr    = AW'(PIXELS - 1);
    write_data = frame_px(PIXELS - 1);
    write_idle();
    check("done_after_frame", 32'(done), 32'd1);

    for (int i = 0; i < PIXELS; i++) read_px("frame", i, 1'b1, frame_px(i));

    // Out-of-range write is dropped and must not alias onto address 0
    write_px(PIXELS, 24'hABCDEF);
    write_idle();
    check("done_after_oor", 32'(done), 32'd1);
    read_px("oor_addr0", 0, 1'b1, 24'h000000);
    read_px("oor_read", 1000, 1'b1, 24'h000000);
    read_px("oor_read_edge", PIXELS, 1'b1, 24'h000000);

    // Read gating
    read_px("gate_off", 10, 1'b0, 24'h000000);
    read_px("gate_on", 10, 1'b1, frame_px(10));

    // Partial frame, reset, then count restarts from zero
    for (int i = 0; i < 500; i++) write_px(i, alt_px(i));
    write_idle();
    rst = 1'b0;
    #2;
    check("done_async_clear", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < PIXELS - 1; i++) write_px(500 + (i % 400), frame_px(500 + (i % 400)));
    @(negedge clk);
    check("done_899_after_rst", 32'(done), 32'd0);
    write_en   = 1'b1;
    wr_addr    = AW'(899);
    write_data = frame_px(899);
    write_idle();
    check("done_900_after_rst", 32'(done), 32'd1);
    for (int i = 0; i < 500; i += 37) read_px("kept", i, 1'b1, alt_px(i));
    read_px("kept_last", 499, 1'b1, alt_px(499));
    read_px("hi_region", 750, 1'b1, frame_px(750));

    // Same-address read and write: no bypass
    write_px(5, 24'h111111);
    write_idle();
    @(negedge clk);
    rd_addr    = AW'(5);
    read_en    = 1'b1;
    wr_addr    = AW'(5);
    write_data = 24'h222222;
    write_en   = 1'b1;
`ifdef MEM_READ_REG_EN
    @(posedge clk);
    #1;
    check("rw_same_first", 32'(read_data), 32'h111111);
    @(negedge clk);
    write_en = 1'b0;
    @(posedge clk);
    #1;
    check("rw_same_next", 32'(read_data), 32'h222222);
`else
    #2;
    check("rw_same_before", 32'(read_data), 32'h111111);
    @(posedge clk);
    #1;
    check("rw_same_after", 32'(read_data), 32'h222222);
    @(negedge clk);
    write_en = 1'b0;
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
